// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared 256kx16 SRAM: VGA reader (R, default priority)
// and renderer writer (W, starvation-protected). Drives every SRAM pin from flops.
module sram_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 6,
    parameter int unsigned RD_CYCLES    = 2,
    parameter int unsigned WR_CYCLES    = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rstbt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_done,
    output logic [ADDR_W-1:0] mem_addr,
    inout  logic [DATA_W-1:0] mem_data,
    output logic              mem_wen,
    output logic              mem_lbn,
    output logic              sram_csn,
    output logic              sram_oen,
    output logic              sdram_csn
);
    localparam int unsigned CYC_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WS, S_WP, S_WH} state_t;

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_ack_q, rd_ack_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_done_q, wr_done_d;
    logic                wen_q, wen_d;
    logic                csn_q, csn_d;
    logic                oen_q, oen_d;
    logic                bus_oe_q, bus_oe_d;
    logic                arb, rd_grant, wr_grant, rd_eff, wr_eff;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_ack_d   = 1'b0;
        rd_valid_d = 1'b0;
        wr_ack_d   = 1'b0;
        wr_done_d  = 1'b0;
        arb        = 1'b0;
        rd_grant   = 1'b0;
        wr_grant   = 1'b0;
        // A request seen while its own ack is still high belongs to the access just granted.
        rd_eff     = rd_req & ~rd_ack_q;
        wr_eff     = wr_req & ~wr_ack_q;

        case (state_q)
            S_IDLE: arb = 1'b1;
            S_RD: begin
                if (cyc_q == CYC_W'(RD_CYCLES - 1)) begin
                    arb        = 1'b1;
                    rd_data_d  = mem_data;
                    rd_valid_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WS: begin
                state_d = S_WP;
                cyc_d   = '0;
            end
            S_WP: begin
                if (cyc_q == CYC_W'(WR_CYCLES - 1)) state_d = S_WH;
                else                                cyc_d   = cyc_q + 1'b1;
            end
            S_WH: begin
                state_d   = S_IDLE;
                wr_done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (arb) begin
            if (starve_q == CNT_W'(STARVE_LIMIT) && wr_eff) wr_grant = 1'b1;
            else if (rd_eff)                               rd_grant = 1'b1;
            else if (wr_eff)                               wr_grant = 1'b1;

            if (rd_grant) begin
                state_d    = S_RD;
                cyc_d      = '0;
                mem_addr_d = rd_addr;
                rd_ack_d   = 1'b1;
            end else if (wr_grant) begin
                state_d    = S_WS;
                mem_addr_d = wr_addr;
                wdata_d    = wr_data;
                wr_ack_d   = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (!wr_req || wr_grant)                      starve_d = '0;
        else if (starve_q != CNT_W'(STARVE_LIMIT))    starve_d = starve_q + 1'b1;
        else                                          starve_d = starve_q;

        // Pin controls are decoded from the next state so they leave the flops glitch-free.
        csn_d    = (state_d == S_IDLE);
        oen_d    = (state_d != S_RD);
        wen_d    = (state_d != S_WP);
        bus_oe_d = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
    end

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            starve_q   <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wen_q      <= 1'b1;
            csn_q      <= 1'b1;
            oen_q      <= 1'b1;
            bus_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            starve_q   <= starve_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_ack_q   <= rd_ack_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            wr_done_q  <= wr_done_d;
            wen_q      <= wen_d;
            csn_q      <= csn_d;
            oen_q      <= oen_d;
            bus_oe_q   <= bus_oe_d;
        end
    end

    assign mem_data  = bus_oe_q ? wdata_q : 'z;
    assign mem_addr  = mem_addr_q;
    assign mem_wen   = wen_q;
    assign mem_lbn   = csn_q;
    assign sram_csn  = csn_q;
    assign sram_oen  = oen_q;
    assign sdram_csn = 1'b1;
    assign rd_ack    = rd_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_ack    = wr_ack_q;
    assign wr_done   = wr_done_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a per-cycle expected pin schedule built from the arbitration
// rules, a pin-level SRAM model with pull-ups on the data bus, and directed scenarios.
module tb_sram_arbiter;
    localparam int unsigned RDC   = 2;
    localparam int unsigned WRC   = 2;
    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        rstbt;
    logic        rd_req, wr_req;
    logic [17:0] rd_addr, wr_addr;
    logic [5:0]  wr_data;
    logic        rd_ack, rd_valid, wr_ack, wr_done;
    logic [5:0]  rd_data;
    logic [17:0] mem_addr;
    wire logic [5:0] mem_data;
    logic        mem_wen, mem_lbn, sram_csn, sram_oen, sdram_csn;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .ADDR_W(18), .DATA_W(6), .RD_CYCLES(RDC), .WR_CYCLES(WRC), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rstbt(rstbt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wen(mem_wen), .mem_lbn(mem_lbn),
        .sram_csn(sram_csn), .sram_oen(sram_oen), .sdram_csn(sdram_csn)
    );

    always #10 clk = ~clk;

    // Released bus reads as all ones.
    for (genvar g = 0; g < 6; g++) begin : g_pu
        pullup (mem_data[g]);
    end

    logic [5:0] sram [0:262143];
    assign mem_data = (!sram_csn && !sram_oen) ? sram[mem_addr] : 'z;

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = '0;
        sram[18'h12345] = 6'h2A;
        forever begin
            @(posedge clk);
            if (!sram_csn && !mem_wen) sram[mem_addr] = mem_data;
        end
    end

    typedef struct packed {
        logic csn, oen, wen, drive, rack, wack, done, rd_last;
        logic [17:0] addr;
        logic [5:0]  wdata;
    } slot_t;

    slot_t       q[$];
    slot_t       cur;
    int unsigned cnt;
    logic        exp_valid;
    logic [5:0]  exp_rd_data;
    logic [17:0] exp_addr;
    logic [5:0]  ref_mem [logic [17:0]];

    function automatic slot_t idle_slot();
        slot_t s;
        s     = '0;
        s.csn = 1'b1;
        s.oen = 1'b1;
        s.wen = 1'b1;
        return s;
    endfunction

    function automatic logic [5:0] ref_read(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 6'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur         = idle_slot();
        cnt         = 0;
        exp_valid   = 1'b0;
        exp_rd_data = '0;
        exp_addr    = '0;
    endtask

    // One clock edge: decide the grant, then queue the pin pattern of every period it covers.
    task automatic model_edge();
        logic rd_eff, wr_eff, rg, wg, vnext;
        logic [5:0] dnext;
        slot_t s;
        rd_eff = rd_req && !cur.rack;
        wr_eff = wr_req && !cur.wack;
        vnext  = cur.rd_last;
        dnext  = ref_read(cur.addr);
        rg = 1'b0;
        wg = 1'b0;
        if (q.size() == 0) begin
            if (cnt == LIMIT && wr_eff) wg = 1'b1;
            else if (rd_eff)            rg = 1'b1;
            else if (wr_eff)            wg = 1'b1;
        end
        if (!wr_req || wg)    cnt = 0;
        else if (cnt < LIMIT) cnt = cnt + 1;
        if (rg) begin
            exp_addr = rd_addr;
            for (int unsigned i = 0; i < RDC; i++) begin
                s         = idle_slot();
                s.csn     = 1'b0;
                s.oen     = 1'b0;
                s.rack    = (i == 0);
                s.rd_last = (i == RDC - 1);
                s.addr    = rd_addr;
                q.push_back(s);
            end
        end
        if (wg) begin
            exp_addr         = wr_addr;
            ref_mem[wr_addr] = wr_data;
            s       = idle_slot();
            s.csn   = 1'b0;
            s.drive = 1'b1;
            s.addr  = wr_addr;
            s.wdata = wr_data;
            s.wack  = 1'b1;
            q.push_back(s);
            s.wack  = 1'b0;
            s.wen   = 1'b0;
            for (int unsigned i = 0; i < WRC; i++) q.push_back(s);
            s.wen   = 1'b1;
            q.push_back(s);
            s       = idle_slot();
            s.done  = 1'b1;
            q.push_back(s);
        end
        cur       = (q.size() != 0) ? q.pop_front() : idle_slot();
        exp_valid = vnext;
        if (vnext) exp_rd_data = dnext;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rstbt) model_reset();
        else        model_edge();
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("rd_ack", rd_ack, cur.rack);
            chk("wr_ack", wr_ack, cur.wack);
            chk("wr_done", wr_done, cur.done);
            chk("rd_valid", rd_valid, exp_valid);
            chk("rd_data", rd_data, exp_rd_data);
            chk("mem_addr", mem_addr, exp_addr);
            chk("sram_csn", sram_csn, cur.csn);
            chk("mem_lbn", mem_lbn, cur.csn);
            chk("sram_oen", sram_oen, cur.oen);
            chk("mem_wen", mem_wen, cur.wen);
            chk("sdram_csn", sdram_csn, 1'b1);
            if (cur.drive)    chk("bus_write", mem_data, cur.wdata);
            else if (cur.oen) chk("bus_released", mem_data, 6'h3F);
        end
    end

    initial begin
        int ndone;
        rstbt   = 1'b0;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        rd_addr = 18'h12345;
        wr_addr = 18'h00001;
        wr_data = 6'h01;
        ref_mem[18'h12345] = 6'h2A;
        model_reset();

        // Reset held with both requests active.
        repeat (3) tick();
        chk("rst_wen", mem_wen, 1'b1);
        chk("rst_csn", sram_csn, 1'b1);
        chk("rst_oen", sram_oen, 1'b1);
        chk("rst_lbn", mem_lbn, 1'b1);
        chk("rst_bus", mem_data, 6'h3F);
        chk("rst_pulses", {rd_ack, rd_valid, wr_ack, wr_done}, 4'b0000);
        chk("rst_addr", mem_addr, 18'h0);
        rd_req = 1'b0;
        wr_req = 1'b0;
        rstbt  = 1'b1;
        tick();

        // Single read.
        rd_addr = 18'h12345;
        rd_req  = 1'b1;
        tick();
        chk("r1_ack_p1", rd_ack, 1'b1);
        chk("r1_oen_p1", sram_oen, 1'b0);
        rd_req = 1'b0;
        tick();
        chk("r1_oen_p2", sram_oen, 1'b0);
        tick();
        chk("r1_valid_p3", rd_valid, 1'b1);
        chk("r1_data_p3", rd_data, 6'h2A);
        chk("r1_oen_p3", sram_oen, 1'b1);
        tick();

        // Single write, then a read of the same word requested while the write is busy.
        wr_addr = 18'h00ABC;
        wr_data = 6'h15;
        wr_req  = 1'b1;
        tick();
        chk("w1_ack_p1", wr_ack, 1'b1);
        chk("w1_ws_wen_p1", mem_wen, 1'b1);
        chk("w1_ws_bus_p1", mem_data, 6'h15);
        wr_req = 1'b0;
        tick();
        chk("w1_wen_p2", mem_wen, 1'b0);
        tick();
        chk("w1_wen_p3", mem_wen, 1'b0);
        rd_addr = 18'h00ABC;
        rd_req  = 1'b1;
        tick();
        chk("w1_wh_wen_p4", mem_wen, 1'b1);
        chk("w1_wh_bus_p4", mem_data, 6'h15);
        tick();
        chk("w1_done_p5", wr_done, 1'b1);
        chk("w1_bus_z_p5", mem_data, 6'h3F);
        chk("w1_oen_p5", sram_oen, 1'b1);
        tick();
        chk("rb_oen_p6", sram_oen, 1'b0);
        chk("rb_ack_p6", rd_ack, 1'b1);
        rd_req = 1'b0;
        tick();
        tick();
        chk("rb_valid_p8", rd_valid, 1'b1);
        chk("rb_data_p8", rd_data, 6'h15);
        tick();

        // Simultaneous requests: read first, write at the read's final edge.
        rd_addr = 18'h12345;
        wr_addr = 18'h3FFFF;
        wr_data = 6'h0A;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        tick();
        chk("sim_rack_p1", rd_ack, 1'b1);
        chk("sim_wack_p1", wr_ack, 1'b0);
        rd_req = 1'b0;
        tick();
        tick();
        chk("sim_rvalid_p3", rd_valid, 1'b1);
        chk("sim_wack_p3", wr_ack, 1'b1);
        wr_req = 1'b0;
        repeat (4) tick();
        chk("sim_done_p7", wr_done, 1'b1);
        tick();

        // Starvation: continuous reads, write must win once the counter reaches the limit.
        rd_addr = 18'h12345;
        wr_addr = 18'h00200;
        wr_data = 6'h33;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        ndone   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (wr_done) ndone++;
            if (i == 8)  chk("stv_wack_p8", wr_ack, 1'b0);
            if (i == 9)  chk("stv_wack_p9", wr_ack, 1'b1);
            if (i == 13) chk("stv_done_p13", wr_done, 1'b1);
            if (i == 14) chk("stv_rack_p14", rd_ack, 1'b1);
            if (cur.wack) wr_req = 1'b0;
        end
        chk("stv_done_count", ndone, 1);
        rd_req = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of the write pulse.
        wr_addr = 18'h3FFFE;
        wr_data = 6'h2A;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        tick();
        chk("ar_wp_wen", mem_wen, 1'b0);
        #3;
        rstbt = 1'b0;
        model_reset();
        #1;
        chk("ar_wen", mem_wen, 1'b1);
        chk("ar_csn", sram_csn, 1'b1);
        chk("ar_bus", mem_data, 6'h3F);
        chk("ar_done", wr_done, 1'b0);
        repeat (2) tick();
        rstbt = 1'b1;
        tick();
        rd_addr = 18'h00ABC;
        rd_req  = 1'b1;
        tick();
        chk("ar_rack", rd_ack, 1'b1);
        rd_req = 1'b0;
        tick();
        tick();
        chk("ar_rvalid", rd_valid, 1'b1);
        chk("ar_rdata", rd_data, 6'h15);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
